// File: rtl/bus_pkg.sv
// Shared CPU-bus definitions used by the bus transmitter and the bus_reader receive FIFO.
package bus_pkg;
    typedef logic [7:0] byte_t;

    // Value seen on an undriven bus, and the reset value of every bus register.
    localparam byte_t BUS_IDLE = 8'hff;
endpackage

// File: rtl/bus_reader_if.sv
// Consumer-side view of bus_reader: bus capture inputs, FIFO drain handshake and status.
interface bus_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    logic [DATA_WIDTH-1:0]  i_bus;
    logic                   i_nLoad;
    logic [DATA_WIDTH-1:0]  o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_full;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_overflow;
    logic                   i_clearOvf;

    modport slave (
        input  i_bus, i_nLoad, i_ready, i_clearOvf,
        output o_data, o_valid, o_full, o_count, o_overflow
    );

    modport master (
        output i_bus, i_nLoad, i_ready, i_clearOvf,
        input  o_data, o_valid, o_full, o_count, o_overflow
    );
endinterface

// File: rtl/bus_reader_wrap_counter.sv
// Modulo-DEPTH pointer with increment enable; DEPTH is a power of two so the wrap is free.
module wrap_counter #(
    parameter int DEPTH = 4,
    parameter int WIDTH = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value
);
    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            value_reg <= '0;
        end else if (i_inc) begin
            value_reg <= value_reg + 1'b1;
        end
    end

    assign o_value = value_reg;
endmodule

// File: rtl/bus_reader.sv
// Receive side of the shared CPU bus: captures bytes while i_nLoad is low into a
// show-ahead FIFO drained by a valid/ready consumer, with a sticky overflow flag.
module bus_reader
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    bus_reader_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Idle pattern widened to DATA_WIDTH so wider buses still read all ones when empty.
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'({((DATA_WIDTH + 7) / 8){BUS_IDLE}});

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  ovf_reg;
    logic                  ovf_next;
    logic                  valid;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign valid = (count_reg != '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign pop   = valid && bus.i_ready;
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign push  = !bus.i_nLoad && (!full || pop);
    assign drop  = !bus.i_nLoad && full && !pop;

    wrap_counter #(.DEPTH(DEPTH), .WIDTH(PW)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (push),
        .o_value (wr_ptr)
    );

    wrap_counter #(.DEPTH(DEPTH), .WIDTH(PW)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (pop),
        .o_value (rd_ptr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    mem_reg[gi] <= IDLE_WORD;
                end else if (push && (wr_ptr == PW'(gi))) begin
                    mem_reg[gi] <= bus.i_bus;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // A drop on the same edge as a clear request keeps the flag set.
    always_comb begin
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (bus.i_clearOvf) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.o_data     = valid ? mem_reg[rd_ptr] : IDLE_WORD;
    assign bus.o_valid    = valid;
    assign bus.o_full     = full;
    assign bus.o_count    = count_reg;
    assign bus.o_overflow = ovf_reg;
endmodule

// File: tb/tb_bus_reader.sv
// Self-checking bench for bus_reader: scoreboard queue of captured bytes plus per-scenario checks.
module tb_bus_reader;
    import bus_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bif ();

    bus_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bif.slave)
    );

    int    checks = 0;
    int    errors = 0;
    byte_t q[$];
    bit    movf = 1'b0;

    // Drives one edge, updates the model and reports any pop that happened on it.
    task automatic drive_edge(input logic nload, input byte_t b, input logic rdy, input logic clr,
                              output bit popped, output byte_t got, output byte_t exp);
        bit pop_m;
        bit push_m;
        bif.i_nLoad    = nload;
        bif.i_bus      = b;
        bif.i_ready    = rdy;
        bif.i_clearOvf = clr;
        pop_m  = (q.size() != 0) && rdy;
        push_m = !nload && ((q.size() < DEPTH) || pop_m);
        got    = bif.o_data;
        exp    = pop_m ? q[0] : BUS_IDLE;
        popped = pop_m;
        @(posedge clk);
        #1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(b);
        if (!nload && !push_m) movf = 1'b1;
        else if (clr) movf = 1'b0;
        $display("t=%0t nload=%b bus=%h ready=%b clr=%b push=%b pop=%b popped_data=%h count=%0d",
                 $time, nload, b, rdy, clr, push_m, pop_m, got, bif.o_count);
        bif.i_nLoad    = 1'b1;
        bif.i_ready    = 1'b0;
        bif.i_clearOvf = 1'b0;
    endtask

    task automatic test_reset();
        bit p; byte_t g, e;
        #12;
        checks++; if (bif.o_data !== 8'hff) begin errors++; $display("FAIL reset_data: got %h expected ff", bif.o_data); end
        checks++; if (bif.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bif.o_valid); end
        checks++; if (bif.o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bif.o_count); end
        @(posedge clk); #1; rst = 1'b0;
        drive_edge(1'b0, 8'h71, 1'b0, 1'b0, p, g, e);
        drive_edge(1'b0, 8'h72, 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_count !== 3'd2) begin errors++; $display("FAIL pre_reset_count: got %0d expected 2", bif.o_count); end
        // Mid-cycle reset must clear everything before the next edge.
        #3; rst = 1'b1; #1;
        q.delete(); movf = 1'b0;
        checks++; if (bif.o_data !== 8'hff) begin errors++; $display("FAIL midreset_data: got %h expected ff", bif.o_data); end
        checks++; if (bif.o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bif.o_valid); end
        checks++; if (bif.o_count !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", bif.o_count); end
        checks++; if (bif.o_overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf: got %b expected 0", bif.o_overflow); end
        checks++; if (bif.o_full !== 1'b0) begin errors++; $display("FAIL midreset_full: got %b expected 0", bif.o_full); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_single();
        bit p; byte_t g, e;
        drive_edge(1'b0, 8'h3c, 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bif.o_valid); end
        checks++; if (bif.o_data !== 8'h3c) begin errors++; $display("FAIL single_data: got %h expected 3c", bif.o_data); end
        checks++; if (bif.o_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bif.o_count); end
        drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
        checks++; if (!p || g !== e) begin errors++; $display("FAIL single_pop: got %h expected %h popped=%b", g, e, p); end
        checks++; if (bif.o_valid !== 1'b0 || bif.o_data !== 8'hff) begin errors++; $display("FAIL single_empty: got valid=%b data=%h expected valid=0 data=ff", bif.o_valid, bif.o_data); end
        // Ready while empty must not move the pointers.
        drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
        checks++; if (bif.o_count !== 3'd0 || bif.o_data !== 8'hff || p) begin errors++; $display("FAIL ready_empty: got count=%0d data=%h expected count=0 data=ff", bif.o_count, bif.o_data); end
    endtask

    task automatic test_fill_overflow();
        bit p; byte_t g, e;
        for (int i = 1; i <= 4; i++) drive_edge(1'b0, byte_t'(i), 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_full !== 1'b1 || bif.o_count !== 3'd4) begin errors++; $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=4", bif.o_full, bif.o_count); end
        drive_edge(1'b0, 8'h05, 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_overflow !== movf || movf !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", bif.o_overflow); end
        checks++; if (bif.o_count !== 3'd4) begin errors++; $display("FAIL fill_ovf_count: got %0d expected 4", bif.o_count); end
        for (int i = 1; i <= 4; i++) begin
            drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
            checks++; if (!p || g !== e || g !== byte_t'(i)) begin errors++; $display("FAIL fill_drain: got %h expected %h", g, byte_t'(i)); end
        end
        checks++; if (bif.o_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got valid=%b expected 0", bif.o_valid); end
        drive_edge(1'b1, 8'h00, 1'b0, 1'b1, p, g, e);
        checks++; if (bif.o_overflow !== 1'b0) begin errors++; $display("FAIL fill_clear: got %b expected 0", bif.o_overflow); end
    endtask

    task automatic test_full_push_pop();
        bit p; byte_t g, e;
        for (int i = 1; i <= 4; i++) drive_edge(1'b0, byte_t'(i), 1'b0, 1'b0, p, g, e);
        drive_edge(1'b0, 8'haa, 1'b1, 1'b0, p, g, e);
        checks++; if (!p || g !== 8'h01) begin errors++; $display("FAIL fpp_pop: got %h expected 01", g); end
        checks++; if (bif.o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", bif.o_overflow); end
        checks++; if (bif.o_data !== 8'h02 || bif.o_count !== 3'd4) begin errors++; $display("FAIL fpp_state: got data=%h count=%0d expected data=02 count=4", bif.o_data, bif.o_count); end
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
            checks++; if (!p || g !== e) begin errors++; $display("FAIL fpp_drain: got %h expected %h", g, e); end
        end
        checks++; if (g !== 8'haa) begin errors++; $display("FAIL fpp_last: got %h expected aa", g); end
    endtask

    task automatic test_wrap();
        bit p; byte_t g, e;
        int k = 0;
        drive_edge(1'b0, 8'h10, 1'b0, 1'b0, p, g, e);
        drive_edge(1'b0, 8'h11, 1'b0, 1'b0, p, g, e);
        for (int i = 2; i < 12; i++) begin
            drive_edge(i < 10 ? 1'b0 : 1'b1, byte_t'(8'h10 + i), 1'b1, 1'b0, p, g, e);
            checks++; if (!p || g !== e || g !== byte_t'(8'h10 + k)) begin errors++; $display("FAIL wrap_pop: got %h expected %h", g, byte_t'(8'h10 + k)); end
            k++;
            if (i < 10) begin
                checks++; if (bif.o_count !== 3'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", bif.o_count); end
            end
        end
        checks++; if (bif.o_valid !== 1'b0 || k != 10) begin errors++; $display("FAIL wrap_end: got valid=%b pops=%0d expected valid=0 pops=10", bif.o_valid, k); end
    endtask

    task automatic test_back_to_back();
        bit p; byte_t g, e;
        for (int i = 0; i < 3; i++) drive_edge(1'b0, 8'h5a, 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bif.o_count); end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
            checks++; if (!p || g !== 8'h5a) begin errors++; $display("FAIL b2b_pop: got %h expected 5a", g); end
        end
    endtask

    task automatic test_ovf_clear();
        bit p; byte_t g, e;
        for (int i = 0; i < 4; i++) drive_edge(1'b0, byte_t'(8'hc0 + i), 1'b0, 1'b0, p, g, e);
        drive_edge(1'b0, 8'h66, 1'b0, 1'b0, p, g, e);
        checks++; if (bif.o_overflow !== 1'b1) begin errors++; $display("FAIL ovfc_set: got %b expected 1", bif.o_overflow); end
        drive_edge(1'b0, 8'h77, 1'b0, 1'b1, p, g, e);
        checks++; if (bif.o_overflow !== 1'b1) begin errors++; $display("FAIL ovfc_priority: got %b expected 1", bif.o_overflow); end
        drive_edge(1'b1, 8'h00, 1'b0, 1'b1, p, g, e);
        checks++; if (bif.o_overflow !== 1'b0) begin errors++; $display("FAIL ovfc_clear: got %b expected 0", bif.o_overflow); end
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b1, 8'h00, 1'b1, 1'b0, p, g, e);
            checks++; if (!p || g !== e || g !== byte_t'(8'hc0 + i)) begin errors++; $display("FAIL ovfc_drain: got %h expected %h", g, byte_t'(8'hc0 + i)); end
        end
    endtask

    initial begin
        bif.i_bus      = 8'h00;
        bif.i_nLoad    = 1'b1;
        bif.i_ready    = 1'b0;
        bif.i_clearOvf = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_back_to_back();
        test_ovf_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
